// File: rtl/pll_ctrl_pkg.sv
// Shared constants for the PLL lock sequencer: state encodings and parameter defaults.
package pll_ctrl_pkg;

  localparam int unsigned DEF_RST_HOLD_CYCLES     = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 65536;
  localparam int unsigned DEF_STABLE_CYCLES       = 1024;
  localparam int unsigned DEF_MAX_RETRIES         = 4;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] RESET_PLL = 3'd0;
  localparam logic [STATE_W-1:0] WAIT_LOCK = 3'd1;
  localparam logic [STATE_W-1:0] STABLE    = 3'd2;
  localparam logic [STATE_W-1:0] RUN       = 3'd3;
  localparam logic [STATE_W-1:0] LOST      = 3'd4;
  localparam logic [STATE_W-1:0] FAULT     = 3'd5;

  // Largest of three cycle counts; sizes the shared state counter.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with synchronous active-low reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back capture flops; the first may go metastable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: holds PLL in reset, qualifies lock with timeout and
// retry budget, releases downstream reset, and restarts on loss of lock.
module pll_lock_sequencer
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned RST_HOLD_CYCLES     = DEF_RST_HOLD_CYCLES,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int unsigned STABLE_CYCLES       = DEF_STABLE_CYCLES,
  parameter int unsigned MAX_RETRIES         = DEF_MAX_RETRIES,
  localparam int unsigned RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               restart,
  input  logic               pll_locked,
  output logic               pll_rst,
  output logic               sys_rst_n,
  output logic               ready,
  output logic               fault,
  output logic [RETRY_W-1:0] retry_count,
  output logic [7:0]         lock_loss_count
);

  localparam int unsigned CNT_MAX = max3(RST_HOLD_CYCLES, LOCK_TIMEOUT_CYCLES, STABLE_CYCLES);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  logic [STATE_W-1:0] state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [RETRY_W-1:0] retry_next;
  logic [7:0]         loss_next;
  logic               enter;
  logic               pll_rst_next, run_next, fault_next;
  logic               lock_s;

  sync_2ff u_lock_sync (
    .clk   (refclk),
    .rst_n (rst),
    .d     (pll_locked),
    .q     (lock_s)
  );

  // Next-state, counter and bookkeeping decode; restart overrides all transitions.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    retry_next = retry_count;
    loss_next  = lock_loss_count;
    enter      = 1'b0;

    if (state == RESET_PLL || state == WAIT_LOCK || state == STABLE) begin
      cnt_next = cnt + CNT_W'(1);
    end

    if (restart) begin
      state_next = RESET_PLL;
      retry_next = '0;
      enter      = 1'b1;
    end else begin
      case (state)
        RESET_PLL: begin
          if (cnt == CNT_W'(RST_HOLD_CYCLES - 1)) begin
            state_next = WAIT_LOCK;
            enter      = 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_next = STABLE;
            enter      = 1'b1;
          end else if (cnt == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
            enter = 1'b1;
            if (retry_count == RETRY_W'(MAX_RETRIES)) begin
              state_next = FAULT;
            end else begin
              state_next = RESET_PLL;
              retry_next = retry_count + RETRY_W'(1);
            end
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state_next = WAIT_LOCK;
            enter      = 1'b1;
          end else if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
            state_next = RUN;
            retry_next = '0;
            enter      = 1'b1;
          end
        end
        RUN: begin
          if (!lock_s) begin
            state_next = LOST;
            enter      = 1'b1;
            if (lock_loss_count != 8'hFF) begin
              loss_next = lock_loss_count + 8'd1;
            end
          end
        end
        LOST: begin
          state_next = RESET_PLL;
          retry_next = '0;
          enter      = 1'b1;
        end
        FAULT: begin
          state_next = FAULT;
        end
        default: begin
          state_next = RESET_PLL;
          retry_next = '0;
          enter      = 1'b1;
        end
      endcase
    end

    if (enter) begin
      cnt_next = '0;
    end

    pll_rst_next = (state_next == RESET_PLL) || (state_next == FAULT);
    run_next     = (state_next == RUN);
    fault_next   = (state_next == FAULT);
  end

  // State, counter and registered outputs, all updated on the same edge.
  always_ff @(posedge refclk) begin
    if (!rst) begin
      state           <= RESET_PLL;
      cnt             <= '0;
      retry_count     <= '0;
      lock_loss_count <= 8'd0;
      pll_rst         <= 1'b1;
      sys_rst_n       <= 1'b0;
      ready           <= 1'b0;
      fault           <= 1'b0;
    end else begin
      state           <= state_next;
      cnt             <= cnt_next;
      retry_count     <= retry_next;
      lock_loss_count <= loss_next;
      pll_rst         <= pll_rst_next;
      sys_rst_n       <= run_next;
      ready           <= run_next;
      fault           <= fault_next;
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer with small cycle parameters.
module tb_pll_lock_sequencer;

  logic       refclk;
  logic       rst;
  logic       restart;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       fault;
  logic [1:0] retry_count;
  logic [7:0] lock_loss_count;

  int cyc;
  int n_cmp;
  int n_bad;

  typedef struct {
    int         cyc;
    logic       locked;
    logic       rs;
    logic       e_pll_rst;
    logic       e_srn;
    logic       e_ready;
    logic       e_fault;
    logic [1:0] e_retry;
    logic [7:0] e_loss;
    string      name;
  } vec_t;

  typedef struct {
    string      name;
    int         cyc;
    logic       pll_rst;
    logic       srn;
    logic       ready;
    logic       fault;
    logic [1:0] retry;
    logic [7:0] loss;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  pll_lock_sequencer #(
    .RST_HOLD_CYCLES     (4),
    .LOCK_TIMEOUT_CYCLES (32),
    .STABLE_CYCLES       (8),
    .MAX_RETRIES         (2)
  ) dut (
    .refclk          (refclk),
    .rst             (rst),
    .restart         (restart),
    .pll_locked      (pll_locked),
    .pll_rst         (pll_rst),
    .sys_rst_n       (sys_rst_n),
    .ready           (ready),
    .fault           (fault),
    .retry_count     (retry_count),
    .lock_loss_count (lock_loss_count)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  function automatic vec_t mk(input int c, input logic lk, input logic rs, input logic pr,
                              input logic sr, input logic rd, input logic f,
                              input logic [1:0] r, input logic [7:0] l, input string n);
    vec_t v;
    v.cyc = c; v.locked = lk; v.rs = rs;
    v.e_pll_rst = pr; v.e_srn = sr; v.e_ready = rd; v.e_fault = f;
    v.e_retry = r; v.e_loss = l; v.name = n;
    return v;
  endfunction

  // One clock; restart is always a single-cycle pulse.
  task automatic step();
    @(posedge refclk);
    #1;
    restart = 1'b0;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    restart = 1'b0;
    pll_locked = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    cyc = 0;
  endtask

  // Record expectation now; DUT output is popped and checked at the falling edge.
  task automatic expect_now(input string n, input logic pr, input logic sr, input logic rd,
                            input logic f, input logic [1:0] r, input logic [7:0] l);
    exp_t e;
    e.name = n; e.cyc = cyc; e.pll_rst = pr; e.srn = sr; e.ready = rd; e.fault = f;
    e.retry = r; e.loss = l;
    sb.push_back(e);
    @(negedge refclk);
    e = sb.pop_front();
    n_cmp++;
    if ({pll_rst, sys_rst_n, ready, fault, retry_count, lock_loss_count} !==
        {e.pll_rst, e.srn, e.ready, e.fault, e.retry, e.loss}) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got pll_rst=%b sys_rst_n=%b ready=%b fault=%b retry=%0d loss=%0d want pll_rst=%b sys_rst_n=%b ready=%b fault=%b retry=%0d loss=%0d",
               e.name, e.cyc, pll_rst, sys_rst_n, ready, fault, retry_count, lock_loss_count,
               e.pll_rst, e.srn, e.ready, e.fault, e.retry, e.loss);
    end
  endtask

  task automatic run_table();
    vec_t v;
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      while (cyc < v.cyc) step();
      pll_locked = v.locked;
      restart = v.rs;
      expect_now(v.name, v.e_pll_rst, v.e_srn, v.e_ready, v.e_fault, v.e_retry, v.e_loss);
    end
    vecs.delete();
  endtask

  task automatic wait_ready(input string n);
    for (int k = 0; k < 64; k++) begin
      if (ready === 1'b1) return;
      step();
    end
    n_cmp++;
    n_bad++;
    $display("FAIL %s cyc=%0d got ready=%b want ready=1 within 64 cycles", n, cyc, ready);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cyc = 0;
    rst = 1'b0;
    restart = 1'b0;
    pll_locked = 1'b0;

    // Normal bring-up with lock raised at cycle 10.
    do_reset();
    vecs.push_back(mk(0,  0, 0, 1, 0, 0, 0, 0, 0, "t1_reset"));
    vecs.push_back(mk(3,  0, 0, 1, 0, 0, 0, 0, 0, "t1_hold_end"));
    vecs.push_back(mk(4,  0, 0, 0, 0, 0, 0, 0, 0, "t1_wait"));
    vecs.push_back(mk(10, 1, 0, 0, 0, 0, 0, 0, 0, "t1_lock_rise"));
    vecs.push_back(mk(13, 1, 0, 0, 0, 0, 0, 0, 0, "t1_stable"));
    vecs.push_back(mk(20, 1, 0, 0, 0, 0, 0, 0, 0, "t1_pre_run"));
    vecs.push_back(mk(21, 1, 0, 0, 1, 1, 0, 0, 0, "t1_run"));
    vecs.push_back(mk(30, 1, 0, 0, 1, 1, 0, 0, 0, "t1_run_hold"));
    run_table();

    // Lock never arrives: three attempts, FAULT, then restart.
    do_reset();
    vecs.push_back(mk(0,   0, 0, 1, 0, 0, 0, 0, 0, "t2_reset"));
    vecs.push_back(mk(3,   0, 0, 1, 0, 0, 0, 0, 0, "t2_hold_end"));
    vecs.push_back(mk(4,   0, 0, 0, 0, 0, 0, 0, 0, "t2_wait1"));
    vecs.push_back(mk(35,  0, 0, 0, 0, 0, 0, 0, 0, "t2_wait1_last"));
    vecs.push_back(mk(36,  0, 0, 1, 0, 0, 0, 1, 0, "t2_retry1"));
    vecs.push_back(mk(39,  0, 0, 1, 0, 0, 0, 1, 0, "t2_retry1_hold"));
    vecs.push_back(mk(40,  0, 0, 0, 0, 0, 0, 1, 0, "t2_wait2"));
    vecs.push_back(mk(72,  0, 0, 1, 0, 0, 0, 2, 0, "t2_retry2"));
    vecs.push_back(mk(107, 0, 0, 0, 0, 0, 0, 2, 0, "t2_wait3_last"));
    vecs.push_back(mk(108, 0, 0, 1, 0, 0, 1, 2, 0, "t2_fault"));
    vecs.push_back(mk(150, 0, 1, 1, 0, 0, 1, 2, 0, "t2_fault_hold"));
    vecs.push_back(mk(151, 0, 0, 1, 0, 0, 0, 0, 0, "t2_restart"));
    vecs.push_back(mk(154, 0, 0, 1, 0, 0, 0, 0, 0, "t2_restart_hold"));
    vecs.push_back(mk(155, 0, 0, 0, 0, 0, 0, 0, 0, "t2_restart_wait"));
    run_table();

    // One-cycle lock glitch in STABLE, then lock drop in RUN.
    do_reset();
    vecs.push_back(mk(0,  0, 0, 1, 0, 0, 0, 0, 0, "t3_reset"));
    vecs.push_back(mk(10, 1, 0, 0, 0, 0, 0, 0, 0, "t3_lock_rise"));
    vecs.push_back(mk(16, 0, 0, 0, 0, 0, 0, 0, 0, "t3_glitch"));
    vecs.push_back(mk(17, 1, 0, 0, 0, 0, 0, 0, 0, "t3_glitch_end"));
    vecs.push_back(mk(21, 1, 0, 0, 0, 0, 0, 0, 0, "t3_no_early_run"));
    vecs.push_back(mk(27, 1, 0, 0, 0, 0, 0, 0, 0, "t3_pre_run"));
    vecs.push_back(mk(28, 1, 0, 0, 1, 1, 0, 0, 0, "t3_run"));
    vecs.push_back(mk(35, 0, 0, 0, 1, 1, 0, 0, 0, "t4_drop"));
    vecs.push_back(mk(37, 0, 0, 0, 1, 1, 0, 0, 0, "t4_drop_sync"));
    vecs.push_back(mk(38, 0, 0, 0, 0, 0, 0, 0, 1, "t4_lost"));
    vecs.push_back(mk(39, 0, 0, 1, 0, 0, 0, 0, 1, "t4_rst_pulse"));
    vecs.push_back(mk(42, 0, 0, 1, 0, 0, 0, 0, 1, "t4_rst_pulse_end"));
    vecs.push_back(mk(43, 0, 0, 0, 0, 0, 0, 0, 1, "t4_wait"));
    run_table();

    // Repeated losses of lock saturate the loss counter.
    pll_locked = 1'b1;
    for (int i = 2; i <= 256; i++) begin
      wait_ready("t4_sat_ready");
      pll_locked = 1'b0;
      step();
      pll_locked = 1'b1;
      step();
      step();
      expect_now("t4_sat_lost", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, (i > 255) ? 8'd255 : 8'(i));
    end

    // Restart from RUN keeps the loss count; then rst mid-STABLE clears everything.
    wait_ready("t5_ready");
    restart = 1'b1;
    step();
    expect_now("t5_restart_run", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd255);
    repeat (7) step();
    expect_now("t5_mid_stable", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd255);
    rst = 1'b0;
    step();
    expect_now("t5_rst_values", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);

    // Restart coincident with the final timeout beats the FAULT transition.
    do_reset();
    vecs.push_back(mk(0,   0, 0, 1, 0, 0, 0, 0, 0, "t6_reset"));
    vecs.push_back(mk(72,  0, 0, 1, 0, 0, 0, 2, 0, "t6_retry2"));
    vecs.push_back(mk(107, 0, 1, 0, 0, 0, 0, 2, 0, "t6_timeout_restart"));
    vecs.push_back(mk(108, 0, 0, 1, 0, 0, 0, 0, 0, "t6_restart_wins"));
    vecs.push_back(mk(111, 0, 0, 1, 0, 0, 0, 0, 0, "t6_hold_end"));
    vecs.push_back(mk(112, 0, 0, 0, 0, 0, 0, 0, 0, "t6_wait"));
    run_table();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
